// File: rtl/svga_timing.sv
// Free-running SVGA raster timing generator: beam position, syncs, display enable.
// All outputs are registered from next-state counter values so they describe one position.
module svga_timing #(
  parameter int H_VIS  = 800,
  parameter int H_FP   = 40,
  parameter int H_SYNC = 128,
  parameter int H_BP   = 88,
  parameter int V_VIS  = 600,
  parameter int V_FP   = 1,
  parameter int V_SYNC = 4,
  parameter int V_BP   = 23,
  parameter bit HS_POL = 1'b1,
  parameter bit VS_POL = 1'b1
) (
  input  logic        clk,
  input  logic        reset_p,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        de,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  if (H_TOT > 4096 || V_TOT > 2048) begin : g_size_chk
    $error("svga_timing: H_TOT/V_TOT exceed x/y port widths");
  end

  localparam logic [11:0] H_LAST  = 12'(H_TOT - 1);
  localparam logic [11:0] H_VIS_L = 12'(H_VIS);
  localparam logic [11:0] HS_BEG  = 12'(H_VIS + H_FP);
  localparam logic [11:0] HS_END  = 12'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST  = 11'(V_TOT - 1);
  localparam logic [10:0] V_VIS_L = 11'(V_VIS);
  localparam logic [10:0] VS_BEG  = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_VIS + V_FP + V_SYNC);

  logic [11:0] r_x;
  logic [10:0] r_y;
  logic        r_de, r_hs, r_vs, r_ls, r_fs;
  logic [15:0] r_fc;

  logic        w_hwrap, w_vwrap;
  logic [11:0] w_x_nxt;
  logic [10:0] w_y_nxt;

  always_comb begin
    w_hwrap = (r_x == H_LAST);
    w_vwrap = (r_y == V_LAST);
    w_x_nxt = w_hwrap ? 12'd0 : r_x + 12'd1;
    w_y_nxt = r_y;
    if (w_hwrap) w_y_nxt = w_vwrap ? 11'd0 : r_y + 11'd1;
  end

  // Decodes use the next position so they land on the same edge as x/y.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_x  <= '0;
      r_y  <= '0;
      r_de <= 1'b1;
      r_ls <= 1'b1;
      r_fs <= 1'b1;
      r_hs <= ~HS_POL;
      r_vs <= ~VS_POL;
      r_fc <= '0;
    end else begin
      r_x  <= w_x_nxt;
      r_y  <= w_y_nxt;
      r_de <= (w_x_nxt < H_VIS_L) && (w_y_nxt < V_VIS_L);
      r_ls <= (w_x_nxt == 12'd0);
      r_fs <= (w_x_nxt == 12'd0) && (w_y_nxt == 11'd0);
      r_hs <= ((w_x_nxt >= HS_BEG) && (w_x_nxt < HS_END)) ? HS_POL : ~HS_POL;
      r_vs <= ((w_y_nxt >= VS_BEG) && (w_y_nxt < VS_END)) ? VS_POL : ~VS_POL;
      if (w_hwrap && w_vwrap) r_fc <= r_fc + 16'd1;
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign de          = r_de;
  assign hsync       = r_hs;
  assign vsync       = r_vs;
  assign line_start  = r_ls;
  assign frame_start = r_fs;
  assign frame_cnt   = r_fc;

endmodule
